// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the EX stage and muldiv_unit.
// The EX stage drives through the master modport; the engine uses the slave modport.
interface muldiv_unit_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 2
);
    logic                  start;
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  flush;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi_result;
    logic [DATA_WIDTH-1:0] lo_result;

    modport master (
        output start, op, operand_1, operand_2, flush,
        input  busy, done, hi_result, lo_result
    );

    modport slave (
        input  start, op, operand_1, operand_2, flush,
        output busy, done, hi_result, lo_result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine with start/busy/done handshake and flush abort.
// Optional MULDIV_FASTPATH_EN: zero-operand multiplies and divide-by-zero skip the CALC phase.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned DW    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             is_uns_q, is_uns_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_neg_q, res_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;

    logic [W-1:0]  abs_a, abs_b;
    logic          a_neg, b_neg;
    logic [W:0]    mul_sum;
    logic [W:0]    div_rem;
    logic [W:0]    div_diff;
    logic [DW-1:0] acc_neg;
    logic [W-1:0]  quo_neg, rem_neg_val;
    logic          mul_zero_c;

    // Datapath helpers shared by PREP, CALC and FIX
    always_comb begin
        a_neg       = ~is_uns_q & a_q[W-1];
        b_neg       = ~is_uns_q & b_q[W-1];
        abs_a       = a_neg ? (~a_q + W'(1)) : a_q;
        abs_b       = b_neg ? (~b_q + W'(1)) : b_q;
        mul_sum     = {1'b0, acc_q[DW-1:W]} + {1'b0, opb_q};
        div_rem     = {acc_q[DW-1:W], acc_q[W-1]};
        div_diff    = div_rem - {1'b0, opb_q};
        acc_neg     = ~acc_q + DW'(1);
        quo_neg     = ~acc_q[W-1:0] + W'(1);
        rem_neg_val = ~acc_q[DW-1:W] + W'(1);
        mul_zero_c  = ~is_div_q & ((a_q == '0) | (b_q == '0));
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        is_uns_d  = is_uns_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    is_div_d = bus.op[1];
                    is_uns_d = bus.op[0];
                    a_d      = bus.operand_1;
                    b_d      = bus.operand_2;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    zero_d    = mul_zero_c;
                    cnt_d     = '0;
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there
                    if (is_div_q) begin
                        acc_d = {{W{1'b0}}, abs_a};
                        opb_d = abs_b;
                    end else begin
                        acc_d = {{W{1'b0}}, abs_b};
                        opb_d = abs_a;
                    end
                    state_d = S_CALC;
`ifdef MULDIV_FASTPATH_EN
                    if (mul_zero_c || (is_div_q && (b_q == '0))) begin
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        // Restoring step: subtract only when no borrow
                        acc_d = {div_diff[W] ? div_rem[W-1:0] : div_diff[W-1:0],
                                 acc_q[W-2:0], ~div_diff[W]};
                    end else if (acc_q[0]) begin
                        acc_d = {mul_sum, acc_q[W-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[DW-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!is_div_q) begin
                        if (zero_q) begin
                            hi_d = '0;
                            lo_d = '0;
                        end else if (res_neg_q) begin
                            hi_d = acc_neg[DW-1:W];
                            lo_d = acc_neg[W-1:0];
                        end else begin
                            hi_d = acc_q[DW-1:W];
                            lo_d = acc_q[W-1:0];
                        end
                    end else if (b_q == '0) begin
                        // Divide by zero: all-ones quotient, remainder is the raw dividend
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = res_neg_q ? quo_neg : acc_q[W-1:0];
                        hi_d = rem_neg_q ? rem_neg_val : acc_q[DW-1:W];
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_PREP) || (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            is_uns_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            is_uns_q  <= is_uns_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hi_result = hi_q;
    assign bus.lo_result = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against an arithmetic reference model.
// Honours MULDIV_FASTPATH_EN when computing expected latency.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [W-1:0] last_hi, last_lo;

    muldiv_unit_if #(.DATA_WIDTH(W), .OP_WIDTH(2)) bus ();

    muldiv_unit #(.DATA_WIDTH(W), .OP_WIDTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] ua, ub;
        logic [W-1:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == '0) begin
                    q = '1;
                    r = a;
                end else if (op == 2'b10) begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {r, q};
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
`ifdef MULDIV_FASTPATH_EN
        if (op[1] == 1'b0 && (a == '0 || b == '0)) return 3;
        if (op[1] == 1'b1 && b == '0) return 3;
`endif
        return W + 3;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    // Issue one operation; optionally present a stray start in cycle 'poke'
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke);
        logic [63:0] exp;
        logic [W-1:0] got_hi, got_lo;
        int lat, dones, busy_n, done_at;
        exp     = model(op, a, b);
        lat     = exp_latency(op, a, b);
        dones   = 0;
        busy_n  = 0;
        done_at = 0;
        got_hi  = '0;
        got_lo  = '0;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_1 = a;
        bus.operand_2 = b;
        step();
        bus.start = 1'b0;
        for (int n = 1; n <= lat + 3; n++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                dones++;
                if (done_at == 0) begin
                    done_at = n;
                    got_hi  = bus.hi_result;
                    got_lo  = bus.lo_result;
                end
            end
            bus.start = 1'b0;
            if (n == poke) begin
                bus.start     = 1'b1;
                bus.op        = 2'($urandom_range(3));
                bus.operand_1 = $urandom;
                bus.operand_2 = $urandom;
            end
            step();
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(done_at), 64'(lat));
        check({tag, " done_pulses"}, 64'(dones), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat - 1));
        check({tag, " hi"}, 64'(got_hi), 64'(exp[63:32]));
        check({tag, " lo"}, 64'(got_lo), 64'(exp[31:0]));
        last_hi = exp[63:32];
        last_lo = exp[31:0];
    endtask

    initial begin
        int dones;
        checks        = 0;
        failures      = 0;
        last_hi       = '0;
        last_lo       = '0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.flush     = 1'b0;
        repeat (3) step();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi_result), 64'd0);
        check("reset lo", 64'(bus.lo_result), 64'd0);
        rst_n = 1'b1;
        step();

        run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        check("mult_neg3x7 hi const", 64'(bus.hi_result), 64'hFFFF_FFFF);
        check("mult_neg3x7 lo const", 64'(bus.lo_result), 64'hFFFF_FFEB);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max hi const", 64'(bus.hi_result), 64'hFFFF_FFFE);
        check("multu_max lo const", 64'(bus.lo_result), 64'h0000_0001);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        check("div_neg7_2 lo const", 64'(bus.lo_result), 64'hFFFF_FFFD);
        check("div_neg7_2 hi const", 64'(bus.hi_result), 64'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf lo const", 64'(bus.lo_result), 64'h8000_0000);
        check("div_ovf hi const", 64'(bus.hi_result), 64'h0);
        run_op("divu_by0", 2'b11, 32'h0000_0064, 32'h0, 0);
        check("divu_by0 lo const", 64'(bus.lo_result), 64'hFFFF_FFFF);
        check("divu_by0 hi const", 64'(bus.hi_result), 64'h64);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FF00, 32'h0, 0);
        run_op("mult_zero", 2'b00, 32'h0, 32'h1234_5678, 0);

        // Flush during a DIVU: abort, results retained, then a fresh MULTU
        bus.start     = 1'b1;
        bus.op        = 2'b11;
        bus.operand_1 = 32'd1000;
        bus.operand_2 = 32'd7;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush busy_c11", 64'(bus.busy), 64'd0);
        check("flush done_c11", 64'(bus.done), 64'd0);
        step();
        check("flush done_c12", 64'(bus.done), 64'd0);
        check("flush hi_kept", 64'(bus.hi_result), 64'(last_hi));
        check("flush lo_kept", 64'(bus.lo_result), 64'(last_lo));
        run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 0);

        // start+flush together: flush wins
        bus.start     = 1'b1;
        bus.flush     = 1'b1;
        bus.op        = 2'b01;
        bus.operand_1 = 32'd3;
        bus.operand_2 = 32'd3;
        step();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start_flush busy", 64'(bus.busy), 64'd0);

        run_op("start_in_calc", 2'b10, 32'hFFFF_F000, 32'd37, 6);

        // Reset in the middle of a DIV
        bus.start     = 1'b1;
        bus.op        = 2'b10;
        bus.operand_1 = 32'd12345;
        bus.operand_2 = 32'd11;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("rst_mid busy", 64'(bus.busy), 64'd0);
        check("rst_mid done", 64'(bus.done), 64'd0);
        check("rst_mid hi", 64'(bus.hi_result), 64'd0);
        check("rst_mid lo", 64'(bus.lo_result), 64'd0);
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 45; n++) begin
            if (bus.done) dones++;
            step();
        end
        check("rst_mid no_done", 64'(dones), 64'd0);

        for (int i = 0; i < 60; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom_range(3)), pick(), pick(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
